// File: rtl/wb_pkg.sv
// Shared writeback-stage constants: result-source select codes, RISC-V load funct3
// encodings and the default datapath width.
package wb_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_ALU2 = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_load_ext.sv
// Load-data lane extraction and sign/zero extension; purely combinational.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      f3,
    input  logic [2:0]      off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ext
);

    // A 32-bit datapath only has four byte lanes, so the top offset bit is dropped.
    logic [2:0]  off_eff;
    logic [7:0]  b_lane;
    logic [15:0] h_lane;
    logic [31:0] w_lane;

    assign off_eff = off & ((XLEN == 64) ? 3'b111 : 3'b011);
    assign b_lane  = 8'(rdata >> {off_eff, 3'b000});
    assign h_lane  = 16'(rdata >> {off_eff[2:1], 4'b0000});
    assign w_lane  = 32'(rdata >> {off_eff[2], 5'b00000});

    always_comb begin
        ext = rdata;
        case (f3)
            F3_LB:   ext = XLEN'($signed(b_lane));
            F3_LBU:  ext = XLEN'(b_lane);
            F3_LH:   ext = XLEN'($signed(h_lane));
            F3_LHU:  ext = XLEN'(h_lane);
            F3_LW:   ext = XLEN'($signed(w_lane));
            F3_LWU:  ext = (XLEN == 64) ? XLEN'(w_lane) : rdata;
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// MEM/WB pipeline register, result select, register-file write port and last-write history.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_mem,
    input  logic [RA_W-1:0] rd_mem,
    input  logic            reg_write_mem,
    input  logic [1:0]      wb_sel_mem,
    input  logic [2:0]      load_f3_mem,
    input  logic [XLEN-1:0] alu_result_mem,
    input  logic [XLEN-1:0] read_data_mem,
    input  logic [XLEN-1:0] pc4_mem,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] write_data_id,
    output logic            reg_write_id,
    output logic [RA_W-1:0] rd_wb_fwd,
    output logic            hist_valid,
    output logic [RA_W-1:0] hist_rd,
    output logic [XLEN-1:0] hist_data
`ifdef WB_RETIRE_CNT_EN
,   output logic [63:0]     retire_cnt
`endif
);

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        wb_sel_e         wb_sel;
        logic [2:0]      f3;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rdata;
        logic [XLEN-1:0] pc4;
    } mem_wb_t;

    mem_wb_t         d, q;
    logic [XLEN-1:0] load_ext;

    always_comb begin
        d           = '0;
        d.valid     = valid_mem;
        d.rd        = rd_mem;
        d.reg_write = reg_write_mem;
        d.wb_sel    = wb_sel_e'(wb_sel_mem);
        d.f3        = load_f3_mem;
        d.alu       = alu_result_mem;
        d.rdata     = read_data_mem;
        d.pc4       = pc4_mem;
    end

    // Flush is applied after the capture so it kills the slot even while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            if (!stall) q <= d;
            if (flush)  q.valid <= 1'b0;
        end
    end

    wb_load_ext #(.XLEN(XLEN)) u_load_ext (
        .f3    (q.f3),
        .off   (q.alu[2:0]),
        .rdata (q.rdata),
        .ext   (load_ext)
    );

    always_comb begin
        write_data_id = q.alu;
        case (q.wb_sel)
            WB_MEM:  write_data_id = load_ext;
            WB_PC4:  write_data_id = q.pc4;
            default: write_data_id = q.alu;
        endcase
    end

    assign reg_write_id = q.valid & q.reg_write & (q.rd != '0);
    assign rd_wb_fwd    = q.valid ? q.rd : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_valid <= 1'b0;
            hist_rd    <= '0;
            hist_data  <= '0;
        end else if (reg_write_id && !stall) begin
            hist_valid <= 1'b1;
            hist_rd    <= q.rd;
            hist_data  <= write_data_id;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                retire_cnt <= '0;
        else if (q.valid && !stall) retire_cnt <= retire_cnt + 64'd1;
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: load extension, result select, history, stall/flush, reset.
module tb_writeback_unit;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_mem;
    logic [RA_W-1:0] rd_mem;
    logic            reg_write_mem;
    logic [1:0]      wb_sel_mem;
    logic [2:0]      load_f3_mem;
    logic [XLEN-1:0] alu_result_mem;
    logic [XLEN-1:0] read_data_mem;
    logic [XLEN-1:0] pc4_mem;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] write_data_id;
    logic            reg_write_id;
    logic [RA_W-1:0] rd_wb_fwd;
    logic            hist_valid;
    logic [RA_W-1:0] hist_rd;
    logic [XLEN-1:0] hist_data;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]     retire_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    writeback_unit #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_mem      (valid_mem),
        .rd_mem         (rd_mem),
        .reg_write_mem  (reg_write_mem),
        .wb_sel_mem     (wb_sel_mem),
        .load_f3_mem    (load_f3_mem),
        .alu_result_mem (alu_result_mem),
        .read_data_mem  (read_data_mem),
        .pc4_mem        (pc4_mem),
        .stall          (stall),
        .flush          (flush),
        .write_data_id  (write_data_id),
        .reg_write_id   (reg_write_id),
        .rd_wb_fwd      (rd_wb_fwd),
        .hist_valid     (hist_valid),
        .hist_rd        (hist_rd),
        .hist_data      (hist_data)
`ifdef WB_RETIRE_CNT_EN
,       .retire_cnt     (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic v, input logic [RA_W-1:0] rd, input logic rw,
                           input logic [1:0] sel, input logic [2:0] f3,
                           input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rdata,
                           input logic [XLEN-1:0] pc4);
        valid_mem      = v;
        rd_mem         = rd;
        reg_write_mem  = rw;
        wb_sel_mem     = sel;
        load_f3_mem    = f3;
        alu_result_mem = alu;
        read_data_mem  = rdata;
        pc4_mem        = pc4;
    endtask

    task automatic chk_hist(input string tag, input logic v, input logic [RA_W-1:0] rd,
                            input logic [XLEN-1:0] data);
        chk({tag, ".hv"}, 64'(hist_valid), 64'(v));
        chk({tag, ".hrd"}, 64'(hist_rd), 64'(rd));
        chk({tag, ".hdata"}, 64'(hist_data), 64'(data));
    endtask

    task automatic chk_cnt(input string tag, input logic [63:0] exp);
`ifdef WB_RETIRE_CNT_EN
        chk(tag, retire_cnt, exp);
`else
        if (exp == 64'hDEAD_0000_0000_0000) $display("unused %s", tag);
`endif
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        set_mem(0, 0, 0, 2'b00, 3'b000, '0, '0, '0);
        tick();
        tick();
        chk("rst.wd", 64'(write_data_id), 64'h0);
        chk("rst.rwid", 64'(reg_write_id), 64'h0);
        chk("rst.fwd", 64'(rd_wb_fwd), 64'h0);
        chk_hist("rst", 1'b0, 5'd0, 32'h0);
        chk_cnt("rst.cnt", 64'h0);
        reset = 1'b0;

        // Load extension cases
        set_mem(1, 5'd3, 1, 2'b01, 3'b000, 32'h0000_1003, 32'h80FF_0000, 32'h0);
        tick();
        chk("lb.wd", 64'(write_data_id), 64'hFFFF_FF80);
        chk("lb.rwid", 64'(reg_write_id), 64'h1);
        chk("lb.fwd", 64'(rd_wb_fwd), 64'd3);

        set_mem(1, 5'd4, 1, 2'b01, 3'b101, 32'h0000_2002, 32'h8001_1234, 32'h0);
        tick();
        chk("lhu.wd", 64'(write_data_id), 64'h0000_8001);
        chk_hist("lhu", 1'b1, 5'd3, 32'hFFFF_FF80);

        set_mem(1, 5'd6, 1, 2'b01, 3'b001, 32'h0000_2002, 32'h8001_1234, 32'h0);
        tick();
        chk("lh.wd", 64'(write_data_id), 64'hFFFF_8001);
        chk_hist("lh", 1'b1, 5'd4, 32'h0000_8001);

        set_mem(1, 5'd9, 1, 2'b01, 3'b100, 32'h0000_0001, 32'h1234_80AB, 32'h0);
        tick();
        chk("lbu.wd", 64'(write_data_id), 64'h0000_0080);

        set_mem(1, 5'd10, 1, 2'b01, 3'b010, 32'h0000_0004, 32'h89AB_CDEF, 32'h0);
        tick();
        chk("lw.wd", 64'(write_data_id), 64'h89AB_CDEF);

        set_mem(1, 5'd11, 1, 2'b01, 3'b011, 32'h0000_0001, 32'h1357_2468, 32'h0);
        tick();
        chk("f3x.wd", 64'(write_data_id), 64'h1357_2468);

        set_mem(1, 5'd12, 1, 2'b11, 3'b000, 32'hCAFE_F00D, 32'h0, 32'h0);
        tick();
        chk("sel11.wd", 64'(write_data_id), 64'hCAFE_F00D);

        // PC+4 result, then rd=0 suppression
        set_mem(1, 5'd5, 1, 2'b10, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h104);
        tick();
        chk("pc4.wd", 64'(write_data_id), 64'h104);
        chk("pc4.rwid", 64'(reg_write_id), 64'h1);
        chk("pc4.fwd", 64'(rd_wb_fwd), 64'd5);
        chk_hist("pc4", 1'b1, 5'd12, 32'hCAFE_F00D);

        set_mem(1, 5'd0, 1, 2'b10, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h104);
        tick();
        chk("rd0.wd", 64'(write_data_id), 64'h104);
        chk("rd0.rwid", 64'(reg_write_id), 64'h0);
        chk_hist("rd0", 1'b1, 5'd5, 32'h104);

        set_mem(0, 0, 0, 2'b00, 3'b000, '0, '0, '0);
        tick();
        chk("bub.rwid", 64'(reg_write_id), 64'h0);
        chk("bub.fwd", 64'(rd_wb_fwd), 64'h0);
        chk_hist("bub", 1'b1, 5'd5, 32'h104);

        // Fresh reset so retire counting starts from a known zero
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        set_mem(1, 5'd7, 1, 2'b00, 3'b000, 32'h1111_2222, 32'h0, 32'h0);
        tick();
        chk("pre.wd", 64'(write_data_id), 64'h1111_2222);
        chk("pre.rwid", 64'(reg_write_id), 64'h1);
        chk_cnt("pre.cnt", 64'd0);

        stall = 1'b1;
        set_mem(1, 5'd8, 1, 2'b00, 3'b000, 32'h3333_4444, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl.wd", 64'(write_data_id), 64'h1111_2222);
            chk("stl.fwd", 64'(rd_wb_fwd), 64'd7);
            chk("stl.hv", 64'(hist_valid), 64'h0);
            chk_cnt("stl.cnt", 64'd0);
        end

        stall = 1'b0;
        tick();
        chk("rel.wd", 64'(write_data_id), 64'h3333_4444);
        chk("rel.fwd", 64'(rd_wb_fwd), 64'd8);
        chk_hist("rel", 1'b1, 5'd7, 32'h1111_2222);
        chk_cnt("rel.cnt", 64'd1);

        stall = 1'b1;
        flush = 1'b1;
        tick();
        chk("sf.fwd", 64'(rd_wb_fwd), 64'h0);
        chk("sf.rwid", 64'(reg_write_id), 64'h0);
        chk("sf.wd", 64'(write_data_id), 64'h3333_4444);
        chk_hist("sf", 1'b1, 5'd7, 32'h1111_2222);
        chk_cnt("sf.cnt", 64'd1);
        stall = 1'b0;
        flush = 1'b0;

        // Asynchronous reset between edges
        set_mem(1, 5'd13, 1, 2'b00, 3'b000, 32'h55AA_55AA, 32'h0, 32'h0);
        tick();
        chk("mid.wd", 64'(write_data_id), 64'h55AA_55AA);
        chk("mid.rwid", 64'(reg_write_id), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.wd", 64'(write_data_id), 64'h0);
        chk("ar.rwid", 64'(reg_write_id), 64'h0);
        chk("ar.fwd", 64'(rd_wb_fwd), 64'h0);
        chk_hist("ar", 1'b0, 5'd0, 32'h0);
        chk_cnt("ar.cnt", 64'd0);
        #1;
        reset = 1'b0;
        tick();
        chk("first.wd", 64'(write_data_id), 64'h55AA_55AA);
        chk("first.fwd", 64'(rd_wb_fwd), 64'd13);
        chk("first.hv", 64'(hist_valid), 64'h0);

`ifdef WB_RETIRE_CNT_EN
        dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        chk("wrap.cnt", retire_cnt, 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width in bits (32 or 64).
REQ-002 The block SHALL have parameter RA_W, default 5, register-address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 The block SHALL have port valid_mem, input, 1, MEM-stage slot holds a real instruction.
REQ-006 The block SHALL have port rd_mem, input, RA_W, destination register.
REQ-007 The block SHALL have port reg_write_mem, input, 1, control-unit write request.
REQ-008 The block SHALL have port wb_sel_mem, input, 2, result source: 00 ALU, 01 MEM, 10 PC+4, 11 ALU.
REQ-009 The block SHALL have port load_f3_mem, input, 3, RISC-V load funct3 (LB/LH/LW/LBU/LHU, plus LD/LWU when XLEN=64).
REQ-010 The block SHALL have ports alu_result_mem, read_data_mem and pc4_mem, input, XLEN each, the three result sources.
REQ-011 The block SHALL have ports stall (hold WB) and flush (kill MEM slot), input, 1 each.
REQ-012 The block SHALL have port write_data_id, output, XLEN, register-file write data.
REQ-013 The block SHALL have ports reg_write_id (output, 1) and rd_wb_fwd (output, RA_W), write enable and address for the register file and forward unit.
REQ-014 The block SHALL have ports hist_valid (output, 1), hist_rd (output, RA_W) and hist_data (output, XLEN), the previous committed write.
REQ-015 The block SHALL have port retire_cnt, output, 64, present only with WB_RETIRE_CNT_EN.

Function
REQ-016 The MEM/WB register SHALL capture valid_mem, rd_mem, reg_write_mem, wb_sel_mem, load_f3_mem, the low 3 bits of alu_result_mem, and all three source buses at each edge when stall=0; latency MEM to WB is 1 cycle.
REQ-017 When stall=1 and flush=0, the register SHALL hold its contents.
REQ-018 When flush=1, captured valid SHALL be 0 regardless of stall; flush wins.
REQ-019 reg_write_id SHALL equal valid_q & reg_write_q & (rd_q != 0); re-asserting on stalled cycles is an idempotent write.
REQ-020 Load data SHALL be extracted at byte offset alu_q[1:0] (alu_q[2:0] for XLEN=64): byte lane for LB/LBU; halfword lane for LH/LHU, ignoring bit 0; word for LW/LWU. Signed loads SHALL sign-extend to XLEN and unsigned loads SHALL zero-extend. Unlisted funct3 values SHALL pass read_data unchanged.
REQ-021 write_data_id SHALL select the extended load for 01, pc4_q for 10, and alu_q otherwise; it is combinational from the register.
REQ-022 rd_wb_fwd SHALL equal rd_q when valid_q=1 and 0 otherwise.
REQ-023 History SHALL load {1, rd_q, write_data_id} at each edge where reg_write_id=1 and stall=0, and hold otherwise; it is not affected by flush.

Reset
REQ-024 Asserting reset SHALL immediately clear valid_q, reg_write_q, hist_valid, and set rd_q, hist_rd and hist_data to 0, making every output 0 (retire_cnt included), mid-stall or mid-flush alike.
REQ-025 The first capture SHALL occur at the first rising edge after reset deasserts.

Configuration
REQ-026 With WB_RETIRE_CNT_EN defined, retire_cnt SHALL increment by 1 at each edge where valid_q=1 and stall=0, wrapping from 2^64-1 to 0.
REQ-027 Without WB_RETIRE_CNT_EN, neither the retire_cnt port nor the counter logic SHALL exist.

Structure
REQ-028 Package wb_pkg SHALL hold the wb_sel codes, load funct3 constants and default XLEN.
REQ-029 Load extension SHALL be sub-module wb_load_ext: combinational, parameterised by XLEN.

Verification
REQ-030 The bench SHALL cover: LB at offset 3, read_data 0x80FF_0000 -> write_data_id 0xFFFF_FF80, 1 cycle after capture.
REQ-031 The bench SHALL cover: LHU at offset 2, read_data 0x8001_1234 -> 0x0000_8001; LH at offset 2 with the same data -> 0xFFFF_8001.
REQ-032 The bench SHALL cover: wb_sel=10, pc4=0x104, rd=5, reg_write=1 -> write_data_id 0x104, reg_write_id 1; repeated with rd=0 -> reg_write_id 0, history unchanged.
REQ-033 The bench SHALL cover: stall held 3 cycles -> outputs frozen, history loaded once, retire_cnt +1 only on release; stall and flush together -> valid_q 0 at the next edge.
REQ-034 The bench SHALL cover: reset asserted between clock edges mid-stream -> all outputs 0 before the next edge; retire_cnt preloaded to 2^64-1 and one retire -> 0.
